// File: rtl/multiplier.sv
// Signed fixed-point sequential multiplier: radix-2 shift-add on magnitudes, WIDTH cycles per product,
// round-half-away-from-zero. Define MULT_SATURATE_EN to clamp overflowed results instead of wrapping.
module multiplier #(
  parameter int WIDTH  = 16,
  parameter int Q_BITS = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2*WIDTH:0]   POS_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH:0]   NEG_MAX = POS_MAX + 1'b1;
  localparam logic [2*WIDTH:0]   RHALF   = (2*WIDTH+1)'(1) << (Q_BITS-1);
  localparam logic [WIDTH-1:0]   MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]      LAST    = CW'(WIDTH-1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic               sign;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH:0]   rounded;
  logic               ovf;
  logic [WIDTH-1:0]   result;

  always_comb begin
    // Two's-complement negate of the most negative value yields 2^(WIDTH-1) as unsigned.
    abs_a   = operand_a[WIDTH-1] ? -operand_a : operand_a;
    abs_b   = operand_b[WIDTH-1] ? -operand_b : operand_b;
    acc_sum = acc + (mplier[0] ? mcand : '0);
    rounded = ({1'b0, acc_sum} + RHALF) >> Q_BITS;
    ovf     = sign ? (rounded > NEG_MAX) : (rounded > POS_MAX);
    result  = sign ? -rounded[WIDTH-1:0] : rounded[WIDTH-1:0];
`ifdef MULT_SATURATE_EN
    if (ovf) result = sign ? MIN_VAL : MAX_VAL;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      valid    <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      sign     <= 1'b0;
      count    <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && ready) begin
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            sign   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            acc    <= '0;
            count  <= '0;
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            product  <= result;
            overflow <= ovf;
            valid    <= 1'b1;
            ready    <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for multiplier at WIDTH=16, Q_BITS=12; expectations hand-computed in Q3.12.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] operand_a, operand_b;
  logic        ready, valid, overflow;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  multiplier #(.WIDTH(16), .Q_BITS(12)) dut (
    .clk(clk), .reset(reset), .start(start),
    .operand_a(operand_a), .operand_b(operand_b),
    .ready(ready), .valid(valid), .product(product), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Drive one request at a negedge, then count rising edges until valid is seen (bounded).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (valid) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; operand_a = '0; operand_b = '0;
    #23;
    checks++;
    if ({ready, valid, overflow, product} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b ovf=%b product=%h, want 1 0 0 0000",
               ready, valid, overflow, product);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_arith;
    logic [15:0] ta[11], tb_[11], tp[11];
    logic        tov[11];
    int lat;
    ta[0]=16'h1800; tb_[0]=16'h2000; tp[0]=16'h3000; tov[0]=0;
    ta[1]=16'hE800; tb_[1]=16'h2000; tp[1]=16'hD000; tov[1]=0;
    ta[2]=16'h0001; tb_[2]=16'h0800; tp[2]=16'h0001; tov[2]=0;
    ta[3]=16'hFFFF; tb_[3]=16'h0800; tp[3]=16'hFFFF; tov[3]=0;
    ta[4]=16'h8000; tb_[4]=16'h1000; tp[4]=16'h8000; tov[4]=0;
    ta[5]=16'h0000; tb_[5]=16'hFFFF; tp[5]=16'h0000; tov[5]=0;
    ta[6]=16'h7FFF; tb_[6]=16'h1000; tp[6]=16'h7FFF; tov[6]=0;
    ta[7]=16'h0003; tb_[7]=16'h0800; tp[7]=16'h0002; tov[7]=0;
`ifdef MULT_SATURATE_EN
    ta[8]=16'h4000; tb_[8]=16'h4000; tp[8]=16'h7FFF; tov[8]=1;
    ta[9]=16'h8000; tb_[9]=16'h1001; tp[9]=16'h8000; tov[9]=1;
    ta[10]=16'h8000; tb_[10]=16'h8000; tp[10]=16'h7FFF; tov[10]=1;
`else
    ta[8]=16'h4000; tb_[8]=16'h4000; tp[8]=16'h0000; tov[8]=1;
    ta[9]=16'h8000; tb_[9]=16'h1001; tp[9]=16'h7FF8; tov[9]=1;
    ta[10]=16'h8000; tb_[10]=16'h8000; tp[10]=16'h0000; tov[10]=1;
`endif
    for (int i = 0; i < 11; i++) begin
      run_op(ta[i], tb_[i], lat);
      checks++;
      if (!valid || lat != 16 || product !== tp[i] || overflow !== tov[i]) begin
        errors++;
        $display("FAIL arith_%0d %h*%h: valid=%b lat=%0d product=%h ovf=%b, want valid=1 lat=16 product=%h ovf=%b",
                 i, ta[i], tb_[i], valid, lat, product, overflow, tp[i], tov[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (valid !== 1'b0 || product !== tp[i] || ready !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b ready=%b product=%h, want 0 1 %h", i, valid, ready, product, tp[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    operand_a = 16'h1800; operand_b = 16'h2000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: ready=%b, want 0", ready);
    end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (lat == 5) begin
        operand_a = 16'h4000; operand_b = 16'h4000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (valid) break;
    end
    start = 1'b0;
    checks++;
    if (!valid || lat != 16 || product !== 16'h3000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: valid=%b lat=%0d product=%h ovf=%b, want 1 16 3000 0",
               valid, lat, product, overflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(16'h1800, 16'h2000, lat);
    // Still inside the valid cycle: request the next operation now.
    operand_a = 16'hE800; operand_b = 16'h2000; start = 1'b1;
    checks++;
    if (!valid || ready !== 1'b1 || product !== 16'h3000) begin
      errors++;
      $display("FAIL b2b_first: valid=%b ready=%b product=%h, want 1 1 3000", valid, ready, product);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (valid !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: valid=%b ready=%b, want 0 0", valid, ready);
    end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (valid) break;
    end
    checks++;
    if (!valid || lat != 16 || product !== 16'hD000) begin
      errors++;
      $display("FAIL b2b_second: valid=%b lat=%0d product=%h, want 1 16 D000", valid, lat, product);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_during_run;
    int lat;
    int seen;
    @(negedge clk);
    operand_a = 16'h4000; operand_b = 16'h2000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ready, valid, overflow, product} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_run: ready=%b valid=%b ovf=%b product=%h, want 1 0 0 0000",
               ready, valid, overflow, product);
    end
    @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    checks++;
    if (seen != 0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL no_pulse_after_abort: pulses=%0d ready=%b, want 0 1", seen, ready);
    end
    run_op(16'h1000, 16'h1000, lat);
    checks++;
    if (!valid || lat != 16 || product !== 16'h1000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op: valid=%b lat=%0d product=%h ovf=%b, want 1 16 1000 0",
               valid, lat, product, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_reset_during_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
